obi_wb_bridge: RTL and testbench
================================

Name: obi_wb_bridge

Overview:
- Bridges the Ibex core's OBI-style memory port (req/gnt/rvalid/err) to a Wishbone B4 pipelined master port.
- Sits directly downstream of the core port and upstream of a Wishbone slave, such as data_mem, or of an instruction memory moved onto Wishbone.
- Tracks outstanding transactions and returns responses in order.
- Responses are registered, one cycle after the Wishbone ack or err.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; sel width is DATA_W/8.
- MAX_OUTST, 2, maximum accepted-but-unanswered transactions (1..7).
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  1  core request.
- gnt  out  1  request accepted this cycle.
- addr  in  ADDR_W  core address.
- we  in  1  write enable.
- be  in  DATA_W/8  byte enables.
- wdata  in  DATA_W  write data.
- rvalid  out  1  response valid.
- rdata  out  DATA_W  read data.
- err  out  1  error response, qualified by rvalid.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_adr  out  ADDR_W  Wishbone address.
- wb_we  out  1  Wishbone write enable.
- wb_sel  out  DATA_W/8  Wishbone byte select.
- wb_dat_o  out  DATA_W  Wishbone write data.
- wb_dat_i  in  DATA_W  Wishbone read data.
- wb_ack  in  1  Wishbone acknowledge.
- wb_err  in  1  Wishbone error.
- wb_stall  in  1  Wishbone stall.

Behaviour:
- Reset state: cnt=0, state=IDLE, rvalid=0, err=0, rdata=0. wb_cyc, wb_stb and gnt read 0 while rst is high.
- Request path is combinational:
  - wb_stb = req && state!=FLUSH && cnt<MAX_OUTST.
  - gnt = wb_stb && !wb_stall.
  - wb_adr, wb_we, wb_sel and wb_dat_o pass addr, we, be and wdata straight through.
- wb_cyc = wb_stb || (cnt!=0 && state!=FLUSH).
- Outstanding counter cnt, width clog2(MAX_OUTST+1):
  - increments on gnt;
  - decrements on (wb_ack||wb_err) when cnt!=0;
  - a grant and a response in the same cycle leave cnt unchanged.
- A response arriving with cnt==0 is ignored: no rvalid, cnt stays 0.
- Response registering: on a response with cnt!=0, the next cycle shows rvalid=1, rdata=wb_dat_i, err=wb_err.
  - Otherwise rvalid=0 and err=0; rdata holds its last value.
  - If ack and err are asserted together, err wins: err=1.
- Latency: the earliest rvalid is 2 cycles after gnt (slave ack in the cycle after grant, plus the response register). Back-to-back acks give back-to-back rvalid.
- States: IDLE (cnt==0), ACTIVE (cnt!=0), FLUSH (optional feature only).
  - IDLE->ACTIVE on gnt.
  - ACTIVE->IDLE when cnt reaches 0.
- Full: at cnt==MAX_OUTST, wb_stb=0 and gnt=0 until a response frees a slot. If a response frees the slot, a request in that same cycle is still blocked; it is granted the following cycle.
- Reset mid-operation: all state clears immediately. Pending Wishbone responses are lost, and later acks are ignored because cnt==0.

Optional Feature:
- Macro: OBI_WB_BRIDGE_TIMEOUT_EN.
- Enabled:
  - A watchdog counter runs while state==ACTIVE. It clears on any response or grant.
  - On reaching TIMEOUT_CYCLES it enters FLUSH. FLUSH forces wb_cyc=0 and wb_stb=0 and ignores wb_ack/wb_err.
  - FLUSH emits one rvalid with err=1 and rdata=0 per cycle, decrementing cnt each time. It returns to IDLE at cnt==0.
- Disabled: no watchdog; FLUSH is unreachable; the bridge waits indefinitely for responses.

Test Plan:
- Single read: addr=0x100, slave acks 1 cycle after grant with 0xDEADBEEF -> gnt in cycle 0, wb_stb high 1 cycle, rvalid=1 with rdata=0xDEADBEEF and err=0 in cycle 2, cnt back to 0.
- Stall: wb_stall held for 3 cycles with req high -> gnt=0 for 3 cycles, wb_stb/wb_adr stable, gnt in cycle 3, exactly one transaction.
- Full window: 3 back-to-back requests, MAX_OUTST=2, slave delays ack 4 cycles -> first 2 granted, third blocked (wb_stb=0) until the first ack, then granted the next cycle; 3 rvalids in order.
- Error: slave returns wb_err on write 0x55AA to 0x200 with be=0x3 -> wb_sel=0x3 observed; rvalid=1, err=1 one cycle later.
- Async reset: assert rst with cnt=2 -> cnt=0, rvalid=0, wb_cyc=0 in the same cycle; a late ack after release produces no rvalid.
- OBI_WB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8: 2 outstanding, no ack -> after 8 idle cycles wb_cyc drops, 2 consecutive rvalid with err=1 and rdata=0, state IDLE, new requests granted afterwards.

Source files
------------

// File: rtl/obi_wb_bridge.sv
// OBI (Ibex core port) to Wishbone B4 pipelined master bridge with in-order registered responses.
// Optional watchdog/flush logic is compiled in with `define OBI_WB_BRIDGE_TIMEOUT_EN.
module obi_wb_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_OUTST      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    // core side
    input  logic                req,
    output logic                gnt,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    // Wishbone side
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic [ADDR_W-1:0]   wb_adr,
    output logic                wb_we,
    output logic [DATA_W/8-1:0] wb_sel,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack,
    input  logic                wb_err,
    input  logic                wb_stall
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          resp;

    // Request path is purely combinational; a full window blocks on the registered count,
    // so a slot freed this cycle is only reusable next cycle.
    assign wb_stb   = !rst && req && (state != FLUSH) && (cnt < CW'(MAX_OUTST));
    assign gnt      = wb_stb && !wb_stall;
    assign wb_cyc   = wb_stb || (!rst && (cnt != '0) && (state != FLUSH));
    assign wb_adr   = addr;
    assign wb_we    = we;
    assign wb_sel   = be;
    assign wb_dat_o = wdata;

    // Responses with nothing outstanding are stray and dropped.
    assign resp = (wb_ack || wb_err) && (cnt != '0) && (state != FLUSH);

    always_comb begin
        // NOTE: default first so every path assigns cnt_next and no latch is inferred.
        cnt_next = cnt;
        if (gnt && !resp) begin
            cnt_next = cnt + CW'(1);
        end else if (!gnt && resp) begin
            cnt_next = cnt - CW'(1);
        end
    end

`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
            wd     <= '0;
`endif
        end else begin
            rvalid <= resp;
            err    <= resp && wb_err;
            if (resp) begin
                rdata <= wb_dat_i;
            end
            cnt   <= cnt_next;
            state <= (cnt_next != '0) ? ACTIVE : IDLE;
`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
            if (state == FLUSH) begin
                // Retire one abandoned transaction per cycle as an error response.
                rvalid <= 1'b1;
                err    <= 1'b1;
                rdata  <= '0;
                cnt    <= cnt - CW'(1);
                state  <= (cnt == CW'(1)) ? IDLE : FLUSH;
                wd     <= '0;
            end else if (state == ACTIVE && !gnt && !resp) begin
                if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                    state <= FLUSH;
                    wd    <= '0;
                end else begin
                    wd <= wd + WW'(1);
                end
            end else begin
                wd <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed self-checking bench for obi_wb_bridge; the timeout scenario runs when
// OBI_WB_BRIDGE_TIMEOUT_EN is defined for both bench and RTL.
module tb_obi_wb_bridge;

`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_adr;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    int errors = 0;
    int checks = 0;

    obi_wb_bridge #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_OUTST(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .addr(addr),
        .we(we),
        .be(be),
        .wdata(wdata),
        .rvalid(rvalid),
        .rdata(rdata),
        .err(err),
        .wb_cyc(wb_cyc),
        .wb_stb(wb_stb),
        .wb_adr(wb_adr),
        .wb_we(wb_we),
        .wb_sel(wb_sel),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack),
        .wb_err(wb_err),
        .wb_stall(wb_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 1'b1; addr = '0; we = 1'b0; be = 4'hF; wdata = '0;
        wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_cyc", wb_cyc, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req = 1'b0;
        step();

        // Single read
        req = 1'b1; addr = 32'h100;
        #1;
        check("rd_gnt", gnt, 1);
        check("rd_stb", wb_stb, 1);
        check("rd_adr", wb_adr, 32'h100);
        step();
        req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
        #1;
        check("rd_stb_drop", wb_stb, 0);
        check("rd_cyc_hold", wb_cyc, 1);
        check("rd_rvalid_early", rvalid, 0);
        step();
        wb_ack = 1'b0;
        #1;
        check("rd_rvalid", rvalid, 1);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        check("rd_err", err, 0);
        check("rd_cnt", dut.cnt, 0);
        check("rd_cyc_idle", wb_cyc, 0);
        step();
        check("rd_rvalid_once", rvalid, 0);
        check("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // Stall
        req = 1'b1; addr = 32'h104; wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_gnt", gnt, 0);
            check("stall_stb", wb_stb, 1);
            check("stall_adr", wb_adr, 32'h104);
            step();
        end
        wb_stall = 1'b0;
        #1;
        check("stall_release_gnt", gnt, 1);
        step();
        req = 1'b0;
        #1;
        check("stall_one_txn", dut.cnt, 1);
        wb_ack = 1'b1; wb_dat_i = 32'h0000_1234;
        step();
        wb_ack = 1'b0;
        #1;
        check("stall_rdata", rdata, 32'h0000_1234);
        check("stall_rvalid", rvalid, 1);
        step();

        // Full window: two granted, third blocked until a slot frees
        req = 1'b1; addr = 32'h10;
        #1 check("full_gnt0", gnt, 1);
        step();
        addr = 32'h14;
        #1 check("full_gnt1", gnt, 1);
        step();
        addr = 32'h18;
        #1;
        check("full_stb_blocked", wb_stb, 0);
        check("full_gnt_blocked", gnt, 0);
        step();
        #1 check("full_gnt_blocked2", gnt, 0);
        step();
        wb_ack = 1'b1; wb_dat_i = 32'hA1;
        #1;
        check("full_gnt_same_cycle", gnt, 0);
        check("full_cyc", wb_cyc, 1);
        step();
        wb_dat_i = 32'hA2;
        #1;
        check("full_gnt_next", gnt, 1);
        check("full_rv1", rvalid, 1);
        check("full_rd1", rdata, 32'hA1);
        step();
        req = 1'b0; wb_dat_i = 32'hA3;
        #1;
        check("full_rd2", rdata, 32'hA2);
        check("full_rv2", rvalid, 1);
        check("full_cnt", dut.cnt, 1);
        step();
        wb_ack = 1'b0;
        #1;
        check("full_rd3", rdata, 32'hA3);
        check("full_rv3", rvalid, 1);
        check("full_cnt_end", dut.cnt, 0);
        step();
        check("full_rv_done", rvalid, 0);

        // Write with slave error
        req = 1'b1; we = 1'b1; addr = 32'h200; wdata = 32'h55AA; be = 4'h3;
        #1;
        check("werr_gnt", gnt, 1);
        check("werr_sel", wb_sel, 32'h3);
        check("werr_we", wb_we, 1);
        check("werr_dat", wb_dat_o, 32'h55AA);
        step();
        req = 1'b0; we = 1'b0; be = 4'hF; wb_err = 1'b1;
        step();
        wb_err = 1'b0;
        #1;
        check("werr_rvalid", rvalid, 1);
        check("werr_err", err, 1);
        step();
        check("werr_err_clear", err, 0);

        // Ack and err together: err wins
        req = 1'b1; addr = 32'h300;
        step();
        req = 1'b0; wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'h77;
        step();
        wb_ack = 1'b0; wb_err = 1'b0;
        #1;
        check("ackerr_rvalid", rvalid, 1);
        check("ackerr_err", err, 1);
        step();

        // Stray ack with nothing outstanding
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        #1;
        check("stray_rvalid", rvalid, 0);
        check("stray_cnt", dut.cnt, 0);

        // Async reset mid-operation
        req = 1'b1; addr = 32'h500;
        step();
        step();
        check("arst_cnt_before", dut.cnt, 2);
        rst = 1'b1;
        #1;
        check("arst_cnt", dut.cnt, 0);
        check("arst_rvalid", rvalid, 0);
        check("arst_cyc", wb_cyc, 0);
        check("arst_gnt", gnt, 0);
        step();
        rst = 1'b0; req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hBAD;
        step();
        wb_ack = 1'b0;
        #1;
        check("arst_late_ack", rvalid, 0);
        check("arst_late_cnt", dut.cnt, 0);

`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
        // Watchdog flush of two abandoned transactions
        req = 1'b1; addr = 32'h400;
        step();
        step();
        req = 1'b0;
        #1;
        n = 0;
        while (wb_cyc === 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("to_cycles", n, 8);
        check("to_rv_flush_entry", rvalid, 0);
        step();
        check("to_rv1", rvalid, 1);
        check("to_err1", err, 1);
        check("to_rd1", rdata, 0);
        step();
        check("to_rv2", rvalid, 1);
        check("to_err2", err, 1);
        check("to_cnt", dut.cnt, 0);
        step();
        check("to_rv_done", rvalid, 0);
        req = 1'b1; addr = 32'h404;
        #1 check("to_regrant", gnt, 1);
        step();
        req = 1'b0; wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
